// File: rtl/trackball_pkg.sv
// Shared types and constants for the trackball-to-ps2_mouse encoder.
// Contents: step_t quadrature step code, ps2_mouse bit positions,
// 9-bit report clamp limits and the quadrature step lookup.
package trackball_pkg;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_t;

  // ps2_mouse word layout
  localparam int unsigned PS2_W      = 25;
  localparam int unsigned PS2_TOGGLE = 24;
  localparam int unsigned PS2_LEFT   = 0;
  localparam int unsigned PS2_ONE    = 3;
  localparam int unsigned PS2_XSIGN  = 4;
  localparam int unsigned PS2_YSIGN  = 5;
  localparam int unsigned PS2_XOVF   = 6;
  localparam int unsigned PS2_YOVF   = 7;

  // Range of a single reported delta (9-bit signed)
  localparam int P9_MAX = 255;
  localparam int P9_MIN = -256;

  // Gray sequence {a,b}: 00 -> 01 -> 11 -> 10 -> 00 counts up.
  function automatic step_t step_lookup(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    case ({prev, cur})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: s = STEP_INC;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: s = STEP_DEC;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: s = STEP_ERR;
      default:                            s = STEP_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/quad_decoder.sv
// One quadrature axis: 2-flop synchronizer, previous-state register and
// step lookup.
// Ports: clk_sys, reset_n (async active-low), a/b raw quadrature pins,
//        step_c decoded step for the current cycle (combinational from
//        registered state).
module quad_decoder
  import trackball_pkg::*;
(
  input  logic  clk_sys,
  input  logic  reset_n,
  input  logic  a,
  input  logic  b,
  output step_t step_c
);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] prev;

  // Synchronizer plus one-deep history of the synced pair
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
      prev  <= 2'b00;
    end else begin
      sync1 <= {a, b};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign step_c = step_lookup(prev, sync2);

endmodule

// File: rtl/trackball_to_mouse.sv
// Arcade trackball to ps2_mouse packet encoder.
// Ports: clk_sys, reset_n (async active-low), enable, qx_a/qx_b and
//        qy_a/qy_b quadrature pins, btn_n fire button (active-low),
//        ps2_mouse 25-bit packet word (bit 24 toggles per packet),
//        quad_err one-cycle pulse on an illegal quadrature transition.
module trackball_to_mouse
  import trackball_pkg::*;
#(
  parameter int unsigned REPORT_DIV = 100000,
  parameter int unsigned ACC_W      = 10
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             qx_a,
  input  logic             qx_b,
  input  logic             qy_a,
  input  logic             qy_b,
  input  logic             btn_n,
  output logic [PS2_W-1:0] ps2_mouse,
  output logic             quad_err
);

  localparam int unsigned CNT_W = $clog2(REPORT_DIV);
  localparam int unsigned AW    = ACC_W + 2;

  localparam logic signed [AW-1:0]    ACC_MAX   = AW'(2**(ACC_W-1) - 1);
  localparam logic signed [AW-1:0]    ACC_MIN   = ~ACC_MAX;
  localparam logic signed [ACC_W-1:0] CLAMP_HI  = ACC_W'(P9_MAX);
  localparam logic signed [ACC_W-1:0] CLAMP_LO  = ACC_W'(P9_MIN);
  localparam logic [PS2_W-1:0]        PKT_RESET = PS2_W'(1) << PS2_ONE;

  typedef enum logic {ST_IDLE, ST_EMIT} state_t;

  state_t                  state;
  state_t                  state_next;
  step_t                   step_x_c;
  step_t                   step_y_c;
  logic [1:0]              btn_sync;
  logic                    btn;
  logic                    last_btn;
  logic [CNT_W-1:0]        tick_cnt;
  logic                    tick_c;
  logic                    emit_c;
  logic signed [ACC_W-1:0] acc_x;
  logic signed [ACC_W-1:0] acc_y;
  logic [8:0]              rep_x_c;
  logic [8:0]              rep_y_c;
  logic                    ovf_x_c;
  logic                    ovf_y_c;
  logic signed [AW-1:0]    sum_x_c;
  logic signed [AW-1:0]    sum_y_c;
  logic [PS2_W-1:0]        packet;
  logic [PS2_W-1:0]        packet_next_c;

  function automatic logic signed [AW-1:0] step_ext(input step_t s);
    logic signed [AW-1:0] v;
    v = '0;
    case (s)
      STEP_INC: v = AW'(1);
      STEP_DEC: v = '1;
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [AW-1:0] v);
    logic signed [ACC_W-1:0] r;
    if (v > ACC_MAX)      r = ACC_W'(ACC_MAX);
    else if (v < ACC_MIN) r = ACC_W'(ACC_MIN);
    else                  r = v[ACC_W-1:0];
    return r;
  endfunction

  function automatic logic [8:0] clamp9(input logic signed [ACC_W-1:0] v);
    logic [8:0] r;
    if (v > CLAMP_HI)      r = 9'h0FF;
    else if (v < CLAMP_LO) r = 9'h100;
    else                   r = v[8:0];
    return r;
  endfunction

  quad_decoder u_dec_x (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .a       (qx_a),
    .b       (qx_b),
    .step_c  (step_x_c)
  );

  quad_decoder u_dec_y (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .a       (qy_a),
    .b       (qy_b),
    .step_c  (step_y_c)
  );

  // Button synchronizer; resets to the released level
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) btn_sync <= 2'b11;
    else          btn_sync <= {btn_sync[0], btn_n};
  end

  assign btn = ~btn_sync[1];

  // Free-running report tick, unaffected by enable
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)    tick_cnt <= '0;
    else if (tick_c) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + CNT_W'(1);
  end

  assign tick_c = (tick_cnt == CNT_W'(REPORT_DIV - 1));

  // FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // FSM next state; disable forces IDLE and suppresses the write
  always_comb begin
    state_next = state;
    emit_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick_c && ((acc_x != '0) || (acc_y != '0) || (btn != last_btn)))
          state_next = ST_EMIT;
      end
      ST_EMIT: begin
        emit_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!enable) begin
      state_next = ST_IDLE;
      emit_c     = 1'b0;
    end
  end

  // Report values, and accumulator update keeping the clamped residue
  always_comb begin
    rep_x_c = clamp9(acc_x);
    rep_y_c = clamp9(acc_y);
    ovf_x_c = (acc_x > CLAMP_HI) || (acc_x < CLAMP_LO);
    ovf_y_c = (acc_y > CLAMP_HI) || (acc_y < CLAMP_LO);
    sum_x_c = {{(AW-ACC_W){acc_x[ACC_W-1]}}, acc_x} + step_ext(step_x_c);
    sum_y_c = {{(AW-ACC_W){acc_y[ACC_W-1]}}, acc_y} + step_ext(step_y_c);
    if (emit_c) begin
      sum_x_c = sum_x_c - {{(AW-9){rep_x_c[8]}}, rep_x_c};
      sum_y_c = sum_y_c - {{(AW-9){rep_y_c[8]}}, rep_y_c};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      acc_x <= '0;
      acc_y <= '0;
    end else if (!enable) begin
      acc_x <= '0;
      acc_y <= '0;
    end else begin
      acc_x <= saturate(sum_x_c);
      acc_y <= saturate(sum_y_c);
    end
  end

  // Packet assembly
  always_comb begin
    packet_next_c             = '0;
    packet_next_c[PS2_TOGGLE] = ~packet[PS2_TOGGLE];
    packet_next_c[23:16]      = rep_y_c[7:0];
    packet_next_c[15:8]       = rep_x_c[7:0];
    packet_next_c[PS2_YOVF]   = ovf_y_c;
    packet_next_c[PS2_XOVF]   = ovf_x_c;
    packet_next_c[PS2_YSIGN]  = rep_y_c[8];
    packet_next_c[PS2_XSIGN]  = rep_x_c[8];
    packet_next_c[PS2_ONE]    = 1'b1;
    packet_next_c[PS2_LEFT]   = btn;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      packet   <= PKT_RESET;
      last_btn <= 1'b0;
      quad_err <= 1'b0;
    end else begin
      if (emit_c) begin
        packet   <= packet_next_c;
        last_btn <= btn;
      end
      quad_err <= (step_x_c == STEP_ERR) || (step_y_c == STEP_ERR);
    end
  end

  assign ps2_mouse = packet;

endmodule

// File: tb/tb_trackball_to_mouse.sv
// Directed self-checking bench for trackball_to_mouse.
module tb_trackball_to_mouse;

  localparam int unsigned DIV = 3200;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b1;
  logic        qx_a    = 1'b0;
  logic        qx_b    = 1'b0;
  logic        qy_a    = 1'b0;
  logic        qy_b    = 1'b0;
  logic        btn_n   = 1'b1;
  logic [24:0] ps2_mouse;
  logic        quad_err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          tb_cnt;
  int          xph = 0;
  int          yph = 0;
  logic        tgl = 1'b0;
  logic [24:0] exp_pkt;
  int          tally;

  always #5 clk_sys = ~clk_sys;

  trackball_to_mouse #(
    .REPORT_DIV (DIV),
    .ACC_W      (10)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .enable    (enable),
    .qx_a      (qx_a),
    .qx_b      (qx_b),
    .qy_a      (qy_a),
    .qy_b      (qy_b),
    .btn_n     (btn_n),
    .ps2_mouse (ps2_mouse),
    .quad_err  (quad_err)
  );

  // Reference phase of the report tick
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) tb_cnt <= 0;
    else          tb_cnt <= (tb_cnt == DIV - 1) ? 0 : tb_cnt + 1;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [24:0] pkt(input logic t, input logic [7:0] y,
                                      input logic [7:0] x, input logic [7:0] st);
    return {t, y, x, st};
  endfunction

  function automatic logic [1:0] gray(input int p);
    logic [1:0] g;
    case (p)
      0:       g = 2'b00;
      1:       g = 2'b01;
      2:       g = 2'b11;
      default: g = 2'b10;
    endcase
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wait_cnt(input int v);
    int guard;
    guard = 0;
    do begin
      @(posedge clk_sys);
      #1;
      guard++;
    end while (tb_cnt != v && guard < DIV + 4);
    check("tick_wait_bound", 32'(tb_cnt), 32'(v));
  endtask

  // Advance through the next tick cycle and its EMIT cycle
  task automatic to_tick();
    wait_cnt(DIV - 1);
    cyc(2);
  endtask

  task automatic step(input bit is_y, input bit fwd, input int gap);
    if (is_y) begin
      yph = (yph + (fwd ? 1 : 3)) % 4;
      {qy_a, qy_b} = gray(yph);
    end else begin
      xph = (xph + (fwd ? 1 : 3)) % 4;
      {qx_a, qx_b} = gray(xph);
    end
    cyc(gap);
  endtask

  initial begin
    // Reset: idle for three ticks, no packet
    cyc(3);
    check("reset_hold", 32'(ps2_mouse), 32'h0000008);
    reset_n = 1'b1;
    tally = 0;
    for (int i = 0; i < 3 * DIV + 2; i++) begin
      cyc(1);
      if (ps2_mouse !== 25'h0000008) tally++;
    end
    check("reset_idle_3ticks", 32'(tally), 32'd0);
    check("reset_quad_err", 32'(quad_err), 32'd0);

    // Forward X: 40 steps
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 20);
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h28, 8'h08);
    check("fwd_x_pkt", 32'(ps2_mouse), 32'(exp_pkt));
    to_tick();
    check("fwd_x_quiet", 32'(ps2_mouse), 32'(exp_pkt));

    // Reverse Y: 300 steps, clamped then residue
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 3);
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h00, 8'hA8);
    check("rev_y300_clamped", 32'(ps2_mouse), 32'(exp_pkt));
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'hD4, 8'h00, 8'h28);
    check("rev_y300_residue", 32'(ps2_mouse), 32'(exp_pkt));

    // Reverse Y: 1000 steps saturate at -512
    for (int i = 0; i < 1000; i++) step(1'b1, 1'b0, 3);
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h00, 8'hA8);
    check("rev_y_sat_first", 32'(ps2_mouse), 32'(exp_pkt));
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h00, 8'h28);
    check("rev_y_sat_second", 32'(ps2_mouse), 32'(exp_pkt));
    to_tick();
    check("rev_y_sat_drained", 32'(ps2_mouse), 32'(exp_pkt));

    // Step landing in the EMIT cycle with 5 pending
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3);
    wait_cnt(DIV - 2);
    step(1'b0, 1'b1, 0);
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h05, 8'h08);
    check("emit_step_first", 32'(ps2_mouse), 32'(exp_pkt));
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h01, 8'h08);
    check("emit_step_residue", 32'(ps2_mouse), 32'(exp_pkt));

    // Button press and release
    btn_n = 1'b0;
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h00, 8'h09);
    check("btn_press", 32'(ps2_mouse), 32'(exp_pkt));
    btn_n = 1'b1;
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h00, 8'h08);
    check("btn_release", 32'(ps2_mouse), 32'(exp_pkt));

    // Illegal X transition: both bits flip
    xph = (xph + 2) % 4;
    {qx_a, qx_b} = gray(xph);
    tally = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (quad_err === 1'b1) tally++;
    end
    check("quad_err_pulses", 32'(tally), 32'd1);
    to_tick();
    check("quad_err_no_motion", 32'(ps2_mouse), 32'(exp_pkt));

    // Disable discards steps; re-enable starts from zero
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3);
    to_tick();
    check("disabled_quiet", 32'(ps2_mouse), 32'(exp_pkt));
    enable = 1'b1;
    to_tick();
    check("reenable_quiet", 32'(ps2_mouse), 32'(exp_pkt));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3);
    to_tick();
    tgl = ~tgl;
    exp_pkt = pkt(tgl, 8'h00, 8'h04, 8'h08);
    check("reenable_accum", 32'(ps2_mouse), 32'(exp_pkt));

    // Async reset during the EMIT cycle
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3);
    wait_cnt(DIV - 1);
    cyc(1);
    reset_n = 1'b0;
    #1;
    tgl = 1'b0;
    exp_pkt = 25'h0000008;
    check("reset_in_emit", 32'(ps2_mouse), 32'(exp_pkt));
    cyc(3);
    reset_n = 1'b1;
    to_tick();
    check("reset_motion_dropped", 32'(ps2_mouse), 32'(exp_pkt));
    check("reset_quad_err_clear", 32'(quad_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
